intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning interrupt source channel count, legal range 1..16.
REQ-002 SHALL have parameter EDGE, default {NCH{1'b1}}, meaning per-channel mode: 1 = rising-edge, 0 = level.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port src  in  NCH  interrupt sources, synchronous to clk.
REQ-006 SHALL have port din  in  16  processor OUT_PORT data.
REQ-007 SHALL have port ld_mask  in  1  decoded write strobe: mask <= din[NCH-1:0].
REQ-008 SHALL have port clr  in  1  decoded write strobe: write-1-to-clear pending/ovf using din[NCH-1:0].
REQ-009 SHALL have port eoi  in  1  decoded write strobe: end of interrupt service.
REQ-010 SHALL have port interrupt_ack  in  1  processor INTERRUPT_ACK, 1-cycle pulse.
REQ-011 SHALL have port interrupt  out  1  registered request to processor INTERRUPT.
REQ-012 SHALL have port vector  out  4  registered index of channel being requested/serviced.
REQ-013 SHALL have port pending  out  NCH  pending flags.
REQ-014 SHALL have port ovf  out  NCH  per-channel overrun flags.
REQ-015 SHALL have port mask  out  NCH  current enable mask.
REQ-016 SHALL have port busy  out  1  high in SERVICE state.

Function
REQ-017 SHALL register src each cycle (src_q); event[i] = src[i] & ~src_q[i] when EDGE[i]=1, else src[i].
REQ-018 SHALL set pending[i] on the clock edge after the cycle event[i] is high (1-cycle latency).
REQ-019 SHALL set ovf[i] when event[i] occurs while pending[i] is already 1.
REQ-020 SHALL clear pending[i] and ovf[i] on clr with din[i]=1; bits with din[i]=0 are unchanged.
REQ-021 SHALL give set priority over clear when event[i] and clr-with-din[i] coincide (pending stays 1, ovf unchanged).
REQ-022 SHALL define active = pending & mask; the lowest-index active bit has highest priority.
REQ-023 SHALL ignore din[15:NCH] on ld_mask and clr.
REQ-024 SHALL implement FSM states IDLE, REQ, SERVICE.
REQ-025 SHALL move IDLE->REQ when active != 0, asserting interrupt and latching vector = highest-priority active index on the same edge.
REQ-026 SHALL stay in REQ holding interrupt=1 and vector stable until interrupt_ack, even if higher-priority channels become active.
REQ-027 SHALL move REQ->SERVICE on interrupt_ack, deasserting interrupt and clearing pending[vector] (auto-acknowledge) on that edge.
REQ-028 SHALL move REQ->IDLE with interrupt deasserted if active becomes 0 before interrupt_ack (masked or cleared withdrawal).
REQ-029 SHALL hold SERVICE, with interrupt=0 and vector retained, until eoi, then go to IDLE.
REQ-030 SHALL not re-request until at least one cycle in IDLE after SERVICE, so back-to-back pending interrupts are separated by at least one cycle of interrupt=0.
REQ-031 SHALL ignore interrupt_ack outside REQ and eoi outside SERVICE.
REQ-032 SHALL keep recording events, and setting pending/ovf, in all FSM states.

Reset
REQ-033 SHALL, while reset=0, asynchronously force FSM=IDLE and interrupt, vector, pending, ovf, mask, src_q, and busy to 0.
REQ-034 SHALL, on reset assertion mid-REQ or mid-SERVICE, drop interrupt immediately, with no ack or eoi required afterwards.
REQ-035 SHALL not register events in the first cycle after reset release unless src is high in that cycle, because src_q=0.

Verification
REQ-036 SHALL cover: NCH=4, mask=4'hF, pulse src[2] -> pending=4'b0100 at next edge; interrupt=1 and vector=2 one edge later; ack -> pending=0, busy=1; eoi -> busy=0.
REQ-037 SHALL cover: src[3] and src[1] rise in the same cycle -> vector=1 first; after ack+eoi, a second request with vector=3 after at least one idle cycle.
REQ-038 SHALL cover: two rising edges on src[0] with no service -> pending[0]=1, ovf[0]=1; clr with din=16'h0001 -> both 0.
REQ-039 SHALL cover: in REQ with vector=2, ld_mask din=0 -> interrupt=0 next edge, FSM=IDLE, pending[2] still 1.
REQ-040 SHALL cover: level channel (EDGE[1]=0) held high through ack -> pending[1] re-sets the cycle after auto-clear; after eoi a new request with vector=1.
REQ-041 SHALL cover: reset asserted mid-SERVICE -> all outputs 0 without a clock edge; normal operation after release.

Source files
------------

// File: rtl/intr_ctrl.sv
// Purpose: prioritised interrupt controller, NCH sources to one processor INTERRUPT line.
// Latency: src event -> pending 1 edge; pending&mask -> interrupt/vector 1 more edge.
// Backpressure: holds the request until interrupt_ack; holds SERVICE until eoi; sources are never stalled.
module intr_ctrl #(
    parameter int             NCH  = 4,
    parameter logic [NCH-1:0] EDGE = {NCH{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] src,
    input  logic [15:0]    din,
    input  logic           ld_mask,
    input  logic           clr,
    input  logic           eoi,
    input  logic           interrupt_ack,
    output logic           interrupt,
    output logic [3:0]     vector,
    output logic [NCH-1:0] pending,
    output logic [NCH-1:0] ovf,
    output logic [NCH-1:0] mask,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [NCH-1:0] src_q;
    logic [NCH-1:0] pending_q,   pending_d;
    logic [NCH-1:0] ovf_q,       ovf_d;
    logic [NCH-1:0] mask_q,      mask_d;
    logic           interrupt_q, interrupt_d;
    logic [3:0]     vector_q,    vector_d;
    logic           busy_q,      busy_d;

    logic [NCH-1:0] evt;
    logic [NCH-1:0] clr_bits;
    logic [NCH-1:0] ack_clr;
    logic [NCH-1:0] active;
    logic [NCH-1:0] active_nxt;
    logic [3:0]     prio_idx;

    // Bits of din above the channel count carry no meaning for this block.
    logic unused_din;
    assign unused_din = ^din;

    // Event detection per channel: rising edge or level, chosen by EDGE.
    always_comb begin
        evt      = (EDGE & src & ~src_q) | (~EDGE & src);
        clr_bits = clr     ? din[NCH-1:0] : '0;
        mask_d   = ld_mask ? din[NCH-1:0] : mask_q;
        active   = pending_q & mask_q;
    end

    // Lowest-index active channel wins.
    always_comb begin
        prio_idx = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (active[i]) prio_idx = 4'(i);
        end
    end

    // Auto-acknowledge: the channel being accepted is cleared on the ack edge.
    always_comb begin
        ack_clr = '0;
        if (state_q == S_REQ && interrupt_ack) begin
            for (int i = 0; i < NCH; i++) begin
                ack_clr[i] = (vector_q == 4'(i));
            end
        end
    end

    // Pending/overrun update: new events beat a software clear, but the
    // auto-ack clear wins so a held level source re-pends one edge later.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (ack_clr[i]) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = evt[i] | (pending_q[i] & ~clr_bits[i]);
            end
            if (evt[i] && clr_bits[i]) begin
                ovf_d[i] = ovf_q[i];
            end else if (clr_bits[i]) begin
                ovf_d[i] = 1'b0;
            end else begin
                ovf_d[i] = ovf_q[i] | (evt[i] & pending_q[i]);
            end
        end
        active_nxt = pending_d & mask_d;
    end

    // Request FSM; withdrawal looks at next-edge mask/pending so a mask or
    // clear write drops the request on the same edge it takes effect.
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        vector_d    = vector_q;
        busy_d      = busy_q;
        unique case (state_q)
            S_IDLE: begin
                if (active != '0) begin
                    state_d     = S_REQ;
                    interrupt_d = 1'b1;
                    vector_d    = prio_idx;
                end
            end
            S_REQ: begin
                if (interrupt_ack) begin
                    state_d     = S_SERVICE;
                    interrupt_d = 1'b0;
                    busy_d      = 1'b1;
                end else if (active_nxt == '0) begin
                    state_d     = S_IDLE;
                    interrupt_d = 1'b0;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                interrupt_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // All state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            mask_q      <= '0;
            interrupt_q <= 1'b0;
            vector_q    <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            mask_q      <= mask_d;
            interrupt_q <= interrupt_d;
            vector_q    <= vector_d;
            busy_q      <= busy_d;
        end
    end

    assign interrupt = interrupt_q;
    assign vector    = vector_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;
    assign mask      = mask_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Purpose: directed self-checking bench for intr_ctrl (NCH=4, channel 1 level, others edge).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none; ack/eoi are driven as directed single-cycle pulses.
module tb_intr_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  src;
    logic [15:0] din;
    logic        ld_mask;
    logic        clr;
    logic        eoi;
    logic        interrupt_ack;
    logic        interrupt;
    logic [3:0]  vector;
    logic [3:0]  pending;
    logic [3:0]  ovf;
    logic [3:0]  mask;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    intr_ctrl #(
        .NCH  (4),
        .EDGE (4'b1101)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src           (src),
        .din           (din),
        .ld_mask       (ld_mask),
        .clr           (clr),
        .eoi           (eoi),
        .interrupt_ack (interrupt_ack),
        .interrupt     (interrupt),
        .vector        (vector),
        .pending       (pending),
        .ovf           (ovf),
        .mask          (mask),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [15:0] v);
        din = v; ld_mask = 1'b1;
        step();
        ld_mask = 1'b0; din = 16'h0;
    endtask

    task automatic write_clr(input logic [15:0] v);
        din = v; clr = 1'b1;
        step();
        clr = 1'b0; din = 16'h0;
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b0; src = 4'h0; din = 16'h0;
        ld_mask = 1'b0; clr = 1'b0; eoi = 1'b0; interrupt_ack = 1'b0;
        step();
        step();
        check("rst_interrupt", {15'h0, interrupt}, 16'h0);
        check("rst_vector",    {12'h0, vector},    16'h0);
        check("rst_pending",   {12'h0, pending},   16'h0);
        check("rst_mask",      {12'h0, mask},      16'h0);
        check("rst_busy",      {15'h0, busy},      16'h0);
        reset = 1'b1;
        step();

        // Single edge source on channel 2
        write_mask(16'h000F);
        check("mask_load", {12'h0, mask}, 16'h000F);
        src = 4'b0100;
        step();
        check("t1_pending", {12'h0, pending}, 16'h0004);
        check("t1_int_lat", {15'h0, interrupt}, 16'h0);
        src = 4'b0000;
        step();
        check("t1_int",    {15'h0, interrupt}, 16'h1);
        check("t1_vector", {12'h0, vector},    16'h2);
        pulse_ack();
        check("t1_ack_pend", {12'h0, pending},   16'h0);
        check("t1_ack_busy", {15'h0, busy},      16'h1);
        check("t1_ack_int",  {15'h0, interrupt}, 16'h0);
        pulse_eoi();
        check("t1_eoi_busy", {15'h0, busy},      16'h0);
        check("t1_eoi_int",  {15'h0, interrupt}, 16'h0);

        // Simultaneous channels 3 and 1; later higher-priority arrival
        src = 4'b1010;
        step();
        check("t2_pending", {12'h0, pending}, 16'h000A);
        src = 4'b0000;
        step();
        check("t2_vec1", {12'h0, vector}, 16'h1);
        pulse_ack();
        check("t2_ack_pend", {12'h0, pending}, 16'h0008);
        pulse_eoi();
        check("t2_idle_gap", {15'h0, interrupt}, 16'h0);
        step();
        check("t2_int3", {15'h0, interrupt}, 16'h1);
        check("t2_vec3", {12'h0, vector},    16'h3);
        src = 4'b0001;
        step();
        src = 4'b0000;
        step();
        check("t2_hold_vec", {12'h0, vector},    16'h3);
        check("t2_hold_int", {15'h0, interrupt}, 16'h1);
        pulse_ack();
        check("t2_pend0", {12'h0, pending}, 16'h0001);
        pulse_eoi();
        step();
        check("t2_vec0", {12'h0, vector}, 16'h0);
        pulse_ack();
        pulse_eoi();
        check("t2_clean", {12'h0, pending}, 16'h0);

        // Overrun and clear, with requests masked off
        write_mask(16'hFFF0);
        check("mask_hi_ignored", {12'h0, mask}, 16'h0);
        src = 4'b0001; step();
        src = 4'b0000; step();
        src = 4'b0001; step();
        src = 4'b0000; step();
        check("t3_pend", {12'h0, pending},   16'h0001);
        check("t3_ovf",  {12'h0, ovf},       16'h0001);
        check("t3_noint",{15'h0, interrupt}, 16'h0);
        write_clr(16'hFFF0);
        check("t3_clr_hi", {12'h0, ovf}, 16'h0001);
        write_clr(16'h0001);
        check("t3_clr_pend", {12'h0, pending}, 16'h0);
        check("t3_clr_ovf",  {12'h0, ovf},     16'h0);
        // Set beats clear on the same edge; overrun untouched
        src = 4'b0001; step();
        src = 4'b0000; step();
        src = 4'b0001; din = 16'h0001; clr = 1'b1;
        step();
        clr = 1'b0; din = 16'h0; src = 4'b0000;
        check("t3_set_win_pend", {12'h0, pending}, 16'h0001);
        check("t3_set_win_ovf",  {12'h0, ovf},     16'h0);
        write_clr(16'h000F);

        // Withdrawal by masking while in REQ; ack outside REQ ignored
        write_mask(16'h000F);
        src = 4'b0100; step();
        src = 4'b0000; step();
        check("t4_vec2", {12'h0, vector}, 16'h2);
        write_mask(16'h0000);
        check("t4_withdraw", {15'h0, interrupt}, 16'h0);
        check("t4_pend2",    {12'h0, pending},   16'h0004);
        pulse_ack();
        check("t4_ack_ign_busy", {15'h0, busy},    16'h0);
        check("t4_ack_ign_pend", {12'h0, pending}, 16'h0004);
        write_clr(16'h0004);
        write_mask(16'h000F);

        // Level channel 1 held through ack
        src = 4'b0010; step();
        check("t5_pend", {12'h0, pending}, 16'h0002);
        step();
        check("t5_vec1", {12'h0, vector}, 16'h1);
        pulse_ack();
        check("t5_autoclr", {12'h0, pending}, 16'h0);
        step();
        check("t5_reset_pend", {12'h0, pending}, 16'h0002);
        check("t5_busy",       {15'h0, busy},    16'h1);
        src = 4'b0000;
        pulse_eoi();
        check("t5_gap", {15'h0, interrupt}, 16'h0);
        step();
        check("t5_reint", {15'h0, interrupt}, 16'h1);
        check("t5_revec", {12'h0, vector},    16'h1);
        pulse_ack();
        pulse_eoi();
        write_clr(16'h000F);
        check("t5_clean_ovf", {12'h0, ovf}, 16'h0);

        // Asynchronous reset mid-SERVICE
        src = 4'b0100; step();
        src = 4'b0000; step();
        pulse_ack();
        src = 4'b1000; step();
        src = 4'b0000;
        check("t6_busy_pre", {15'h0, busy}, 16'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_busy",    {15'h0, busy},      16'h0);
        check("t6_int",     {15'h0, interrupt}, 16'h0);
        check("t6_vector",  {12'h0, vector},    16'h0);
        check("t6_pending", {12'h0, pending},   16'h0);
        check("t6_mask",    {12'h0, mask},      16'h0);
        check("t6_ovf",     {12'h0, ovf},       16'h0);
        step();
        reset = 1'b1;
        step();
        write_mask(16'h000F);
        src = 4'b0001; step();
        src = 4'b0000; step();
        check("t6_post_int", {15'h0, interrupt}, 16'h1);
        check("t6_post_vec", {12'h0, vector},    16'h0);
        pulse_ack();
        check("t6_post_busy", {15'h0, busy}, 16'h1);
        pulse_eoi();
        check("t6_post_idle", {15'h0, busy}, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
